// File: rtl/td4_sequencer.sv
// Fetch/decode/execute controller for the 4-bit TD4 datapath: PC, IR, carry flag, ROM handshake.
// Optional build macro TD4_SINGLE_STEP_EN adds step_i and a HOLD state for single-stepping.
module td4_sequencer #(
    parameter int                  PC_WIDTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef TD4_SINGLE_STEP_EN
    input  logic                step_i,
`endif
    output logic                rom_req,
    output logic [PC_WIDTH-1:0] rom_addr,
    input  logic                rom_ack,
    input  logic [7:0]          rom_data,
    input  logic                alu_carry_i,
    output logic [1:0]          src_sel,
    output logic [3:0]          imm_o,
    output logic                ld_a,
    output logic                ld_b,
    output logic                ld_out,
    output logic                carry_o,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                illegal_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
`ifdef TD4_SINGLE_STEP_EN
        , HOLD = 2'd3
`endif
    } state_t;

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] pc, pc_nxt;
    logic [7:0]          ir;
    logic                carry, carry_nxt;
    logic [PC_WIDTH-1:0] target;

    assign rom_addr = pc;
    assign pc_o     = pc;
    assign imm_o    = ir[3:0];
    assign carry_o  = carry;
    assign target   = PC_WIDTH'(ir[3:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
            ir    <= '0;
            carry <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == FETCH && rom_ack)
                ir <= rom_data;
            if (state == EXEC) begin
                pc    <= pc_nxt;
                carry <= carry_nxt;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rom_req   = 1'b0;
        src_sel   = 2'b00;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_out    = 1'b0;
        illegal_o = 1'b0;
        carry_nxt = 1'b0;
        pc_nxt    = pc + PC_WIDTH'(1);
        case (state)
            IDLE: begin
`ifdef TD4_SINGLE_STEP_EN
                state_nxt = HOLD;
`else
                state_nxt = FETCH;
`endif
            end
            FETCH: begin
                rom_req = 1'b1;
                if (rom_ack)
                    state_nxt = EXEC;
            end
            EXEC: begin
`ifdef TD4_SINGLE_STEP_EN
                state_nxt = HOLD;
`else
                state_nxt = FETCH;
`endif
                // Strobes decode straight from ir; only ADD A/ADD B keep the adder carry.
                case (ir[7:4])
                    4'b0000: begin src_sel = 2'b01; ld_a = 1'b1; carry_nxt = alu_carry_i; end
                    4'b0001: begin src_sel = 2'b10; ld_a = 1'b1; end
                    4'b0010: begin src_sel = 2'b11; ld_a = 1'b1; end
                    4'b0011: begin src_sel = 2'b00; ld_a = 1'b1; end
                    4'b0100: begin src_sel = 2'b01; ld_b = 1'b1; end
                    4'b0101: begin src_sel = 2'b10; ld_b = 1'b1; carry_nxt = alu_carry_i; end
                    4'b0110: begin src_sel = 2'b11; ld_b = 1'b1; end
                    4'b0111: begin src_sel = 2'b00; ld_b = 1'b1; end
                    4'b1001: begin src_sel = 2'b10; ld_out = 1'b1; end
                    4'b1011: begin src_sel = 2'b00; ld_out = 1'b1; end
                    4'b1110: begin
                        if (!carry)
                            pc_nxt = target;
                    end
                    4'b1111: pc_nxt = target;
                    default: illegal_o = 1'b1;
                endcase
            end
`ifdef TD4_SINGLE_STEP_EN
            HOLD: begin
                if (step_i)
                    state_nxt = FETCH;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_td4_sequencer.sv
// Directed bench for td4_sequencer: ROM responder with programmable ack delay, cycle-exact checks.
module tb_td4_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       step_i;
    logic       rom_req;
    logic [3:0] rom_addr;
    logic       rom_ack;
    logic [7:0] rom_data;
    logic       alu_carry_i;
    logic [1:0] src_sel;
    logic [3:0] imm_o;
    logic       ld_a, ld_b, ld_out;
    logic       carry_o;
    logic [3:0] pc_o;
    logic       illegal_o;

    logic [7:0] prog [16];
    int         ack_wait;
    int         req_cnt;
    int         n_tests;
    int         n_fail;

    always #5 clk = ~clk;

    td4_sequencer #(.PC_WIDTH(4), .RESET_PC(4'd0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef TD4_SINGLE_STEP_EN
        .step_i      (step_i),
`endif
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .rom_ack     (rom_ack),
        .rom_data    (rom_data),
        .alu_carry_i (alu_carry_i),
        .src_sel     (src_sel),
        .imm_o       (imm_o),
        .ld_a        (ld_a),
        .ld_b        (ld_b),
        .ld_out      (ld_out),
        .carry_o     (carry_o),
        .pc_o        (pc_o),
        .illegal_o   (illegal_o)
    );

    // ROM answers after ack_wait cycles of continuous request.
    assign rom_data = prog[rom_addr];
    assign rom_ack  = rom_req && (req_cnt >= ack_wait);

    always @(posedge clk) begin
        if (rom_req && !rom_ack)
            req_cnt <= req_cnt + 1;
        else
            req_cnt <= 0;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [7:0] lds();
        return {5'b0, ld_a, ld_b, ld_out};
    endfunction

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        req_cnt     = 0;
        ack_wait    = 0;
        rst_n       = 1'b0;
        step_i      = 1'b0;
        alu_carry_i = 1'b0;
        for (int i = 0; i < 16; i++) prog[i] = 8'h30;
        prog[0]  = 8'h33; prog[1]  = 8'h52; prog[2]  = 8'h90; prog[3]  = 8'hF5;
        prog[5]  = 8'h37; prog[6]  = 8'hFA; prog[8]  = 8'hC0; prog[9]  = 8'hFF;
        prog[10] = 8'h0F; prog[11] = 8'hE8; prog[12] = 8'h0F; prog[13] = 8'hE8;
        prog[15] = 8'h31;

        repeat (3) tick();
        check("rst_req",   rom_req, 0);
        check("rst_pc",    pc_o, 0);
        check("rst_carry", carry_o, 0);
        check("rst_lds",   lds(), 0);
        check("rst_ill",   illegal_o, 0);
        check("rst_imm",   imm_o, 0);
        rst_n = 1'b1;

`ifdef TD4_SINGLE_STEP_EN
        repeat (10) begin
            tick();
            check("hold_req", rom_req, 0);
        end
        step_i = 1'b1;
        tick();
        step_i = 1'b0;
        check("step_fetch_req",  rom_req, 1);
        check("step_fetch_addr", rom_addr, 0);
        tick();
        check("step_exec_lda", ld_a, 1);
        tick();
        check("step_hold_req", rom_req, 0);
        check("step_hold_lds", lds(), 0);
        check("step_hold_pc",  pc_o, 1);
        tick();
        check("step_hold2_req", rom_req, 0);
`else
        // Zero-wait ROM: MOV A,3 / ADD B,2 / OUT B
        tick();
        check("t1_f0_req",  rom_req, 1);
        check("t1_f0_addr", rom_addr, 0);
        check("t1_f0_lds",  lds(), 0);
        tick();
        check("t1_e0_lds", lds(), 8'b100);
        check("t1_e0_src", src_sel, 0);
        check("t1_e0_imm", imm_o, 3);
        check("t1_e0_req", rom_req, 0);
        tick();
        check("t1_f1_pc", pc_o, 1);
        tick();
        check("t1_e1_lds", lds(), 8'b010);
        check("t1_e1_src", src_sel, 2);
        check("t1_e1_imm", imm_o, 2);
        tick();
        check("t1_f2_pc", pc_o, 2);
        tick();
        check("t1_e2_lds", lds(), 8'b001);
        check("t1_e2_src", src_sel, 2);
        tick();
        check("t1_f3_pc", pc_o, 3);
        tick();
        check("jmp5_lds", lds(), 0);
        check("jmp5_ill", illegal_o, 0);

        // Delayed ack at pc=5
        ack_wait = 3;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("t2_req",  rom_req, 1);
            check("t2_addr", rom_addr, 5);
            check("t2_lds",  lds(), 0);
            check("t2_imm",  imm_o, 5);
            check("t2_ack",  rom_ack, (k == 3) ? 1 : 0);
            if (k < 3) tick();
        end
        tick();
        ack_wait = 0;
        check("t2_exec_lda", lds(), 8'b100);
        check("t2_exec_imm", imm_o, 7);
        tick();
        check("t2_f6_pc", pc_o, 6);
        tick();
        tick();
        check("jmpA_pc", pc_o, 10);

        // Carry and JNC
        alu_carry_i = 1'b1;
        tick();
        check("add_lda",   lds(), 8'b100);
        check("add_src",   src_sel, 1);
        check("add_carry", carry_o, 0);
        tick();
        check("add_pc",    pc_o, 11);
        check("add_carry1", carry_o, 1);
        tick();
        check("jnc_c1_lds",   lds(), 0);
        check("jnc_c1_carry", carry_o, 1);
        tick();
        check("jnc_c1_pc",    pc_o, 12);
        check("jnc_c1_clr",   carry_o, 0);
        alu_carry_i = 1'b0;
        tick();
        tick();
        check("add0_pc",    pc_o, 13);
        check("add0_carry", carry_o, 0);
        alu_carry_i = 1'b1;
        tick();
        tick();
        check("jnc_c0_pc",    pc_o, 8);
        check("jnc_c0_carry", carry_o, 0);

        // Illegal opcode, JMP 15, wrap
        alu_carry_i = 1'b0;
        tick();
        check("ill_pulse", illegal_o, 1);
        check("ill_lds",   lds(), 0);
        tick();
        check("ill_drop", illegal_o, 0);
        check("ill_pc",   pc_o, 9);
        tick();
        tick();
        check("jmpF_pc", pc_o, 15);
        tick();
        check("wrap_lda", lds(), 8'b100);
        tick();
        check("wrap_pc", pc_o, 0);

        // Reset during EXEC of MOV A,3
        tick();
        check("t5_lda_before", ld_a, 1);
        rst_n = 1'b0;
        #1;
        check("t5_lda_drop", ld_a, 0);
        check("t5_pc",       pc_o, 0);
        check("t5_carry",    carry_o, 0);
        check("t5_req",      rom_req, 0);
        check("t5_imm",      imm_o, 0);
        tick();
        rst_n = 1'b1;
        check("t5_idle_req", rom_req, 0);
        tick();
        check("t5_f_req",  rom_req, 1);
        check("t5_f_addr", rom_addr, 0);
        tick();
        check("t5_e_lda", lds(), 8'b100);
        check("t5_e_imm", imm_o, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
